// File: rtl/eth_pkg.sv
// Shared constants, state encoding and helpers for the GMII Ethernet receive parser.
package eth_pkg;

   localparam logic [7:0]  PRE           = 8'h55;
   localparam logic [7:0]  SFD           = 8'hD5;
   localparam logic [15:0] ETYPE_IPV4    = 16'h0800;
   localparam logic [15:0] ETYPE_ARP     = 16'h0806;
   localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;
   localparam logic [15:0] MIN_PAYLOAD   = 16'd46;
   localparam int          FCS_BYTES     = 4;
   localparam int          BUF_DEPTH     = FCS_BYTES + 1;

   typedef enum logic [3:0] {
      ST_SYNC,
      ST_IDLE,
      ST_PRE,
      ST_DST,
      ST_SRC,
      ST_TYPE,
      ST_PAY,
      ST_DROP,
      ST_STATUS
   } state_e;

   function automatic logic [31:0] bitrev32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

endpackage

// File: rtl/rx_crc32.sv
// Byte-wide Ethernet CRC-32 accumulator (reflected, init all ones, no final inversion).
module rx_crc32 import eth_pkg::*; (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init_i,
   input  logic        en_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   localparam logic [31:0] POLY_REFL = bitrev32(CRC32_POLY);

   logic [31:0] crc_q;
   logic [31:0] crc_d;

   // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
   always_comb begin
      crc_d = crc_q ^ {24'h0, data_i};
      for (int i = 0; i < 8; i++) begin
         crc_d = crc_d[0] ? ((crc_d >> 1) ^ POLY_REFL) : (crc_d >> 1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || init_i) crc_q <= '1;
      else if (en_i)        crc_q <= crc_d;
   end

   assign crc_o = crc_q;

endmodule

// File: rtl/rx_eth_parser.sv
// GMII receive front end: preamble/SFD sync, MAC filter, EtherType demux, FCS strip, frame status.
// Define RX_ETH_FCS_CHECK_EN to build the CRC-32 check; otherwise fcs_ok is constant 1.
module rx_eth_parser import eth_pkg::*; #(
   parameter int                   OCT          = 8,
   parameter int                   NUM_CH       = 2,
   parameter logic [NUM_CH*16-1:0] ETYPE_LIST   = {16'h0806, 16'h0800},
   parameter int                   MAX_PAYLOAD  = 1500,
   parameter bit                   ACCEPT_BCAST = 1'b1,
   localparam int                  CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic            RX_CLK,
   input  logic            rst_n,
   input  logic [47:0]     mac_addr,
   input  logic            promisc,
   input  logic            RX_DV,
   input  logic [OCT-1:0]  RXD,
   input  logic            RX_ER,
   output logic [OCT-1:0]  rx_data,
   output logic            rx_valid,
   output logic            rx_sof,
   output logic            rx_eof,
   output logic [CW-1:0]   rx_chan,
   output logic [47:0]     rx_mac_src,
   output logic            rx_done,
   output logic            rx_good,
   output logic [15:0]     rx_len,
   output logic [15:0]     rx_drop_cnt
);

   localparam logic [15:0] LEN_MAX = 16'(MAX_PAYLOAD);
   localparam logic [15:0] LEN_CAP = 16'(MAX_PAYLOAD + 1);

   state_e          state_q;
   logic [2:0]      cnt_q;
   logic [47:0]     dst_q, src_q;
   logic [OCT-1:0]  type_hi_q;
   logic [OCT-1:0]  buf_q [BUF_DEPTH];
   logic [2:0]      fill_q;
   logic            sof_pend_q, err_q, ovs_q;
   logic [15:0]     len_q;

   logic [OCT-1:0]  rx_data_q;
   logic            rx_valid_q, rx_sof_q, rx_eof_q, rx_done_q, rx_good_q;
   logic [CW-1:0]   rx_chan_q;
   logic [47:0]     rx_mac_src_q;
   logic [15:0]     rx_len_q, rx_drop_cnt_q;

   logic [47:0]     dst_d, src_d;
   logic [15:0]     type_d, len_d, drop_cnt_d;
   logic [CW-1:0]   chan_d;
   logic            chan_hit, dst_hit, hdr_err, buf_full, good_d, fcs_ok;

   assign dst_d      = {dst_q[47-OCT:0], RXD};
   assign src_d      = {src_q[47-OCT:0], RXD};
   assign type_d     = {type_hi_q, RXD};
   assign dst_hit    = (dst_d == mac_addr) || (ACCEPT_BCAST && (dst_d == BCAST_MAC)) || promisc;
   assign hdr_err    = !RX_DV || RX_ER;
   assign buf_full   = (fill_q == 3'(BUF_DEPTH));
   assign len_d      = (len_q == LEN_CAP) ? len_q : len_q + 16'd1;
   assign drop_cnt_d = (rx_drop_cnt_q == 16'hFFFF) ? rx_drop_cnt_q : rx_drop_cnt_q + 16'd1;
   assign good_d     = !err_q && !ovs_q && (len_q >= MIN_PAYLOAD) && (len_q <= LEN_MAX) && fcs_ok;

   // Scan from the top so the lowest matching index is the one left standing.
   always_comb begin
      chan_d   = '0;
      chan_hit = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ETYPE_LIST[16*i +: 16] == type_d) begin
            chan_d   = CW'(i);
            chan_hit = 1'b1;
         end
      end
   end

`ifdef RX_ETH_FCS_CHECK_EN
   logic [31:0] crc;
   logic        crc_init, crc_en;

   assign crc_init = (state_q == ST_PRE) && RX_DV && !RX_ER && (RXD == SFD);
   assign crc_en   = RX_DV && ((state_q == ST_DST) || (state_q == ST_SRC) ||
                               (state_q == ST_TYPE) || (state_q == ST_PAY));

   rx_crc32 u_crc (
      .clk    (RX_CLK),
      .rst_n  (rst_n),
      .init_i (crc_init),
      .en_i   (crc_en),
      .data_i (RXD),
      .crc_o  (crc)
   );

   assign fcs_ok = (bitrev32(crc) == CRC32_RESIDUE);
`else
   assign fcs_ok = 1'b1;
`endif

   // NOTE: the payload delay line has no reset; fill_q, which is reset, says which entries are live.
   always_ff @(posedge RX_CLK) begin
      if ((state_q == ST_PAY) && RX_DV) begin
         buf_q[0] <= RXD;
         for (int i = 1; i < BUF_DEPTH; i++) buf_q[i] <= buf_q[i-1];
      end
   end

   // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge register values.
   always_ff @(posedge RX_CLK) begin
      if (!rst_n) begin
         state_q       <= ST_SYNC;
         cnt_q         <= '0;
         dst_q         <= '0;
         src_q         <= '0;
         type_hi_q     <= '0;
         fill_q        <= '0;
         sof_pend_q    <= 1'b0;
         err_q         <= 1'b0;
         ovs_q         <= 1'b0;
         len_q         <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         rx_sof_q      <= 1'b0;
         rx_eof_q      <= 1'b0;
         rx_done_q     <= 1'b0;
         rx_good_q     <= 1'b0;
         rx_chan_q     <= '0;
         rx_mac_src_q  <= '0;
         rx_len_q      <= '0;
         rx_drop_cnt_q <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         rx_sof_q   <= 1'b0;
         rx_eof_q   <= 1'b0;
         rx_done_q  <= 1'b0;
         unique case (state_q)
            ST_SYNC: if (!RX_DV) state_q <= ST_IDLE;
            ST_IDLE: if (RX_DV) state_q <= ST_PRE;
            ST_PRE: begin
               if (!RX_DV) begin
                  rx_drop_cnt_q <= drop_cnt_d;
                  state_q       <= ST_IDLE;
               end else if (RX_ER || ((RXD != PRE) && (RXD != SFD))) begin
                  rx_drop_cnt_q <= drop_cnt_d;
                  state_q       <= ST_DROP;
               end else if (RXD == SFD) begin
                  cnt_q   <= '0;
                  state_q <= ST_DST;
               end
            end
            ST_DST, ST_SRC, ST_TYPE: begin
               if (hdr_err) begin
                  rx_drop_cnt_q <= drop_cnt_d;
                  state_q       <= RX_DV ? ST_DROP : ST_IDLE;
               end else begin
                  cnt_q <= cnt_q + 3'd1;
                  case (state_q)
                     ST_DST: begin
                        dst_q <= dst_d;
                        if (cnt_q == 3'd5) begin
                           cnt_q <= '0;
                           if (dst_hit) state_q <= ST_SRC;
                           else begin
                              rx_drop_cnt_q <= drop_cnt_d;
                              state_q       <= ST_DROP;
                           end
                        end
                     end
                     ST_SRC: begin
                        src_q <= src_d;
                        if (cnt_q == 3'd5) begin
                           cnt_q   <= '0;
                           state_q <= ST_TYPE;
                        end
                     end
                     default: begin
                        type_hi_q <= RXD;
                        if (cnt_q == 3'd1) begin
                           if (chan_hit) begin
                              rx_chan_q    <= chan_d;
                              rx_mac_src_q <= src_q;
                              fill_q       <= '0;
                              len_q        <= '0;
                              err_q        <= 1'b0;
                              ovs_q        <= 1'b0;
                              sof_pend_q   <= 1'b1;
                              state_q      <= ST_PAY;
                           end else begin
                              rx_drop_cnt_q <= drop_cnt_d;
                              state_q       <= ST_DROP;
                           end
                        end
                     end
                  endcase
               end
            end
            ST_PAY: begin
               // With the buffer full the oldest entry is payload; on RX_DV fall it is the last one.
               if (buf_full) begin
                  rx_data_q  <= buf_q[BUF_DEPTH-1];
                  rx_valid_q <= 1'b1;
                  rx_sof_q   <= sof_pend_q;
                  rx_eof_q   <= !RX_DV;
                  sof_pend_q <= 1'b0;
                  len_q      <= len_d;
                  ovs_q      <= ovs_q || (len_d > LEN_MAX);
               end
               if (RX_DV) begin
                  if (RX_ER)     err_q  <= 1'b1;
                  if (!buf_full) fill_q <= fill_q + 3'd1;
               end else begin
                  state_q <= ST_STATUS;
               end
            end
            ST_STATUS: begin
               rx_done_q <= 1'b1;
               rx_good_q <= good_d;
               rx_len_q  <= len_q;
               if (!good_d) rx_drop_cnt_q <= drop_cnt_d;
               state_q   <= RX_DV ? ST_PRE : ST_IDLE;
            end
            ST_DROP: if (!RX_DV) state_q <= ST_IDLE;
            default: state_q <= ST_SYNC;
         endcase
      end
   end

   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign rx_sof      = rx_sof_q;
   assign rx_eof      = rx_eof_q;
   assign rx_chan     = rx_chan_q;
   assign rx_mac_src  = rx_mac_src_q;
   assign rx_done     = rx_done_q;
   assign rx_good     = rx_good_q;
   assign rx_len      = rx_len_q;
   assign rx_drop_cnt = rx_drop_cnt_q;

endmodule

// File: tb/tb_rx_eth_parser.sv
// Self-checking bench for rx_eth_parser: directed frame table, reset/sync sequence, random frames.
module tb_rx_eth_parser;

`ifdef RX_ETH_FCS_CHECK_EN
   localparam bit FCS_ON = 1'b1;
`else
   localparam bit FCS_ON = 1'b0;
`endif

   localparam logic [47:0] MAC   = 48'h02_00_00_AB_CD_EF;
   localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
   localparam logic [47:0] OTHER = 48'h02_11_22_33_44_55;
   localparam logic [47:0] S1 = 48'h00_1B_21_00_00_01, S2 = 48'h00_1B_21_00_00_02;
   localparam logic [47:0] S3 = 48'h00_1B_21_00_00_03, S4 = 48'h00_1B_21_00_00_04;
   localparam logic [47:0] S5 = 48'h00_1B_21_00_00_05;

   typedef struct {
      logic [47:0] dst;
      logic [47:0] src;
      logic [15:0] etype;
      int          plen;
      bit          promisc;
      int          er_at;
      bit          bad_fcs;
      bit          acc;
      int          chan;
      bit          good;
      int          len;
   } vec_t;

   logic        RX_CLK = 1'b0;
   logic        rst_n = 1'b0;
   logic [47:0] mac_addr = MAC;
   logic        promisc = 1'b0;
   logic        RX_DV = 1'b0;
   logic [7:0]  RXD = 8'h00;
   logic        RX_ER = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, rx_eof, rx_chan, rx_done, rx_good;
   logic [47:0] rx_mac_src;
   logic [15:0] rx_len, rx_drop_cnt;

   int          n_cmp = 0;
   int          n_fail = 0;
   logic [9:0]  got_q[$], exp_q[$];
   logic [16:0] done_q[$], exp_done_q[$];
   logic [7:0]  fr_q[$], pl_q[$];
   int          exp_drop = 0;
   int          exp_chan = 0;
   logic [47:0] exp_src = '0;
   vec_t        tbl[13];

   rx_eth_parser dut (
      .RX_CLK      (RX_CLK),
      .rst_n       (rst_n),
      .mac_addr    (mac_addr),
      .promisc     (promisc),
      .RX_DV       (RX_DV),
      .RXD         (RXD),
      .RX_ER       (RX_ER),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_sof      (rx_sof),
      .rx_eof      (rx_eof),
      .rx_chan     (rx_chan),
      .rx_mac_src  (rx_mac_src),
      .rx_done     (rx_done),
      .rx_good     (rx_good),
      .rx_len      (rx_len),
      .rx_drop_cnt (rx_drop_cnt)
   );

   always #5 RX_CLK = ~RX_CLK;

   always @(negedge RX_CLK) begin
      if (rx_valid) got_q.push_back({rx_data, rx_sof, rx_eof});
      if (rx_done)  done_q.push_back({rx_good, rx_len});
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] fcs32(input logic [7:0] q[$], input int from);
      logic [31:0] c = '1;
      for (int i = from; i < q.size(); i++) begin
         c ^= {24'h0, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
      return ~c;
   endfunction

   // Expected outcome of a frame from the receive rules alone.
   function automatic vec_t model(input vec_t v);
      vec_t r = v;
      bit   dst_ok = (v.dst == MAC) || (v.dst == BCAST) || v.promisc;
      bit   typ_ok = (v.etype == 16'h0800) || (v.etype == 16'h0806);
      r.acc  = dst_ok && typ_ok;
      r.chan = (v.etype == 16'h0800) ? 0 : 1;
      r.len  = (v.plen > 1501) ? 1501 : v.plen;
      r.good = (v.er_at < 0) && (v.plen >= 46) && (v.plen <= 1500) && !(v.bad_fcs && FCS_ON);
      return r;
   endfunction

   function automatic vec_t mk(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et,
                               input int plen, input bit pr, input int er, input bit bf,
                               input bit acc, input int ch, input bit good, input int len);
      vec_t v;
      v.dst = dst; v.src = src; v.etype = et; v.plen = plen; v.promisc = pr; v.er_at = er;
      v.bad_fcs = bf; v.acc = acc; v.chan = ch; v.good = good; v.len = len;
      return v;
   endfunction

   task automatic drive(input logic dv, input logic [7:0] d, input logic er);
      @(negedge RX_CLK);
      RX_DV = dv;
      RXD   = d;
      RX_ER = er;
   endtask

   task automatic build_frame(input vec_t v);
      logic [31:0] fcs;
      fr_q.delete();
      pl_q.delete();
      for (int i = 0; i < 7; i++) fr_q.push_back(8'h55);
      fr_q.push_back(8'hD5);
      for (int i = 5; i >= 0; i--) fr_q.push_back(v.dst[8*i +: 8]);
      for (int i = 5; i >= 0; i--) fr_q.push_back(v.src[8*i +: 8]);
      fr_q.push_back(v.etype[15:8]);
      fr_q.push_back(v.etype[7:0]);
      for (int i = 0; i < v.plen; i++) begin
         pl_q.push_back(8'($urandom));
         fr_q.push_back(pl_q[i]);
      end
      fcs = fcs32(fr_q, 8);
      for (int i = 0; i < 4; i++) fr_q.push_back(fcs[8*i +: 8] ^ ((v.bad_fcs && i == 0) ? 8'h01 : 8'h00));
   endtask

   task automatic send_frame(input vec_t v, input int gap);
      build_frame(v);
      promisc = v.promisc;
      foreach (fr_q[i]) drive(1'b1, fr_q[i], (v.er_at >= 0) && (i == 22 + v.er_at));
      repeat (gap) drive(1'b0, 8'h00, 1'b0);
      if (v.acc) begin
         for (int i = 0; i < v.plen; i++) exp_q.push_back({pl_q[i], i == 0, i == v.plen - 1});
         exp_done_q.push_back({v.good, 16'(v.len)});
         exp_chan = v.chan;
         exp_src  = v.src;
      end
      if (!v.acc || !v.good) exp_drop++;
   endtask

   task automatic drain(input string tag);
      int errs;
      repeat (12) @(negedge RX_CLK);
      check({tag, ".bytes"}, got_q.size(), exp_q.size());
      errs = 0;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) errs++;
      check({tag, ".stream_errs"}, errs, 0);
      check({tag, ".dones"}, done_q.size(), exp_done_q.size());
      errs = 0;
      for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) if (done_q[i] !== exp_done_q[i]) errs++;
      check({tag, ".status_errs"}, errs, 0);
      check({tag, ".drop_cnt"}, rx_drop_cnt, exp_drop);
      check({tag, ".chan"}, rx_chan, exp_chan);
      check({tag, ".mac_src"}, rx_mac_src, exp_src);
      got_q.delete(); exp_q.delete(); done_q.delete(); exp_done_q.delete();
   endtask

   initial begin
      //           dst    src etype     plen pr  er  bf  acc ch good  len
      tbl[0]  = mk(MAC,   S1, 16'h0800,   46, 0, -1, 0,  1, 0, 1,     46);
      tbl[1]  = mk(BCAST, S2, 16'h0806,   60, 0, -1, 0,  1, 1, 1,     60);
      tbl[2]  = mk(OTHER, S3, 16'h0806,   60, 0, -1, 0,  0, 1, 0,     0);
      tbl[3]  = mk(MAC,   S4, 16'h86DD,   50, 0, -1, 0,  0, 1, 0,     0);
      tbl[4]  = mk(MAC,   S5, 16'h0800,   64, 0, -1, 0,  1, 0, 1,     64);
      tbl[5]  = mk(MAC,   S1, 16'h0800,  100, 0, 50, 0,  1, 0, 0,     100);
      tbl[6]  = mk(MAC,   S2, 16'h0806,   50, 0, -1, 1,  1, 1, !FCS_ON, 50);
      tbl[7]  = mk(OTHER, S3, 16'h0800,   46, 1, -1, 0,  1, 0, 1,     46);
      tbl[8]  = mk(MAC,   S4, 16'h0800,   45, 0, -1, 0,  1, 0, 0,     45);
      tbl[9]  = mk(MAC,   S5, 16'h0806, 1500, 0, -1, 0,  1, 1, 1,     1500);
      tbl[10] = mk(MAC,   S1, 16'h0800, 1502, 0, -1, 0,  1, 0, 0,     1501);
      tbl[11] = mk(MAC,   S2, 16'h0806,    1, 0, -1, 0,  1, 1, 0,     1);
      tbl[12] = mk(BCAST, S3, 16'h0800,    0, 0, -1, 0,  1, 0, 0,     0);

      repeat (3) @(negedge RX_CLK);
      check("reset_outputs", {rx_data, rx_valid, rx_sof, rx_eof, rx_done, rx_good, rx_len, rx_drop_cnt, rx_chan}, 0);
      check("reset_mac_src", rx_mac_src, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge RX_CLK);

      for (int t = 0; t < 13; t++) begin
         send_frame(tbl[t], 1);
         drain($sformatf("vec%0d", t));
      end

      // Reset mid-payload with RX_DV held: 30 payload bytes in, 25 of them already streamed.
      build_frame(mk(MAC, S4, 16'h0806, 60, 0, -1, 0, 1, 1, 1, 60));
      promisc = 1'b0;
      for (int i = 0; i < 52; i++) drive(1'b1, fr_q[i], 1'b0);
      @(negedge RX_CLK);
      rst_n = 1'b0;
      RXD   = fr_q[52];
      @(negedge RX_CLK);
      check("midreset_outputs", {rx_data, rx_valid, rx_sof, rx_eof, rx_done, rx_good, rx_len, rx_drop_cnt, rx_chan}, 0);
      check("midreset_mac_src", rx_mac_src, 0);
      for (int i = 0; i < 25; i++) exp_q.push_back({pl_q[i], i == 0, 1'b0});
      exp_drop = 0;
      exp_chan = 0;
      exp_src  = '0;
      @(negedge RX_CLK);
      rst_n = 1'b1;
      for (int i = 54; i < fr_q.size(); i++) drive(1'b1, fr_q[i], 1'b0);
      repeat (3) drive(1'b0, 8'h00, 1'b0);
      send_frame(mk(MAC, S5, 16'h0800, 48, 0, -1, 0, 1, 0, 1, 48), 1);
      drain("after_reset");

      for (int n = 0; n < 40; n++) begin
         vec_t v;
         int   pick;
         pick  = $urandom_range(0, 3);
         v.dst = (pick == 0) ? BCAST : (pick == 3) ? (48'h0200_0000_0000 | 48'($urandom)) : MAC;
         v.src = {16'($urandom), 32'($urandom)};
         pick  = $urandom_range(0, 4);
         v.etype   = (pick == 0) ? 16'h86DD : (pick < 3) ? 16'h0800 : 16'h0806;
         v.plen    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(40, 70));
         v.promisc = ($urandom_range(0, 5) == 0);
         v.er_at   = (v.plen > 0 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, v.plen - 1)) : -1;
         v.bad_fcs = ($urandom_range(0, 7) == 0);
         v = model(v);
         send_frame(v, $urandom_range(1, 3));
      end
      drain("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
